// File: rtl/core_pkg.sv
// Shared core definitions: producer latency classes and register index type.
// No ports; imported by the scoreboard and its counter cells.
package core_pkg;

    localparam int unsigned NUM_REGS_DEF = 32;
    localparam int unsigned ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

    // Stall cycles a back-to-back dependent needs behind each producer class.
    localparam int unsigned LAT_ALU  = 0;
    localparam int unsigned LAT_LOAD = 1;
    localparam int unsigned LAT_MUL  = 3;

    typedef logic [ADDR_W_DEF-1:0] regidx_t;

endpackage

// File: rtl/sb_counter.sv
// Per-register scoreboard cell: a LAT_W down-counter that stops at zero.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   load_i       load load_val_i (wins over the decrement)
//   load_val_i   latency to load
//   clear_i      force to zero (wins over load)
//   nonzero_o    registered count is nonzero
module sb_counter #(
    parameter int unsigned LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [LAT_W-1:0] load_val_i,
    input  logic             clear_i,
    output logic             nonzero_o
);

    logic [LAT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - LAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Latency-driven hazard scoreboard beside the decode stage. Tracks, per register,
// the cycles until a producer's result can be forwarded; raises the decode stall,
// cancels the entry of a producer squashed in execute, and counts stall cycles.
// Ports:
//   clk, rst                    clock and asynchronous active-high reset
//   id_valid                    valid instruction in decode
//   id_rs1/id_rs2               source indices, id_use_rs1/id_use_rs2 qualify them
//   id_rd, id_reg_write, id_lat destination, write enable, producer latency
//   flush_e                     branch taken in execute, squash decode and execute
//   stall_d                     combinational decode stall
//   pending_mask                registered per-register "entry live" view
//   stall_count                 saturating count of stalled cycles
module hazard_scoreboard
    import core_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned LAT_W    = 3,
    parameter int unsigned PERF_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [ADDR_W-1:0]   id_rs1,
    input  logic [ADDR_W-1:0]   id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic [ADDR_W-1:0]   id_rd,
    input  logic                id_reg_write,
    input  logic [LAT_W-1:0]    id_lat,
    input  logic                flush_e,
    output logic                stall_d,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic [PERF_W-1:0]   stall_count
);

    logic [NUM_REGS-1:0] pend;
    logic                hit_rs1, hit_rs2;
    logic                issue;
    logic                set_entry;

    logic [ADDR_W-1:0]   last_rd_q, last_rd_d;
    logic                last_set_q, last_set_d;
    logic [PERF_W-1:0]   stall_count_q, stall_count_d;

    // x0 never holds an entry.
    assign pend[0] = 1'b0;

    always_comb begin
        hit_rs1 = id_use_rs1 && (id_rs1 != '0) && pend[id_rs1];
        hit_rs2 = id_use_rs2 && (id_rs2 != '0) && pend[id_rs2];
        // Flush beats stall: the decode instruction is discarded anyway.
        stall_d   = id_valid && !flush_e && (hit_rs1 || hit_rs2);
        issue     = id_valid && !stall_d && !flush_e;
        set_entry = issue && id_reg_write && (id_rd != '0) && (id_lat != LAT_W'(LAT_ALU));
    end

    genvar r;
    generate
        for (r = 1; r < NUM_REGS; r++) begin : g_cnt
            logic load_r;
            logic clear_r;

            assign load_r  = set_entry && (id_rd == ADDR_W'(r));
            // Only the instruction issued last cycle can be sitting in execute.
            assign clear_r = flush_e && last_set_q && (last_rd_q == ADDR_W'(r));

            sb_counter #(
                .LAT_W (LAT_W)
            ) u_cnt (
                .clk        (clk),
                .rst        (rst),
                .load_i     (load_r),
                .load_val_i (id_lat),
                .clear_i    (clear_r),
                .nonzero_o  (pend[r])
            );
        end
    endgenerate

    always_comb begin
        last_rd_d     = last_rd_q;
        last_set_d    = set_entry;
        stall_count_d = stall_count_q;
        if (issue) begin
            last_rd_d = id_rd;
        end
        if (stall_d && (stall_count_q != {PERF_W{1'b1}})) begin
            stall_count_d = stall_count_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_rd_q     <= '0;
            last_set_q    <= 1'b0;
            stall_count_q <= '0;
        end else begin
            last_rd_q     <= last_rd_d;
            last_set_q    <= last_set_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign pending_mask = pend;
    assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned LAT_W    = 3;
    localparam int unsigned PERF_W   = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                id_valid;
    logic [ADDR_W-1:0]   id_rs1, id_rs2, id_rd;
    logic                id_use_rs1, id_use_rs2, id_reg_write;
    logic [LAT_W-1:0]    id_lat;
    logic                flush_e;
    logic                stall_d;
    logic [NUM_REGS-1:0] pending_mask;
    logic [PERF_W-1:0]   stall_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .LAT_W    (LAT_W),
        .PERF_W   (PERF_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_lat       (id_lat),
        .flush_e      (flush_e),
        .stall_d      (stall_d),
        .pending_mask (pending_mask),
        .stall_count  (stall_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic s, input logic [31:0] pm,
                        input logic [31:0] sc);
        check({tag, "_stall"}, {31'b0, stall_d}, {31'b0, s});
        check({tag, "_pmask"}, pending_mask, pm);
        check({tag, "_scnt"}, {28'b0, stall_count}, sc);
    endtask

    // Advance to the next falling edge, apply decode inputs, settle.
    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic wr, input logic [2:0] lat, input logic fl);
        @(negedge clk);
        id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = wr; id_lat = lat; flush_e = fl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0);
    endtask

    function automatic logic [31:0] bit_of(input int r);
        logic [31:0] m;
        m = '0;
        m[r] = 1'b1;
        return m;
    endfunction

    initial begin
        logic [31:0] exp_sc;
        rst = 1'b1;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_reg_write = 0; id_lat = 0; flush_e = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            idle();
            chk3("idle", 1'b0, 32'h0, 32'd0);
        end

        // lw x5 then add x6,x5,x1: one bubble.
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
        chk3("lw_issue", 1'b0, 32'h0, 32'd0);
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0);
        chk3("lu_stall", 1'b1, bit_of(5), 32'd0);
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0);
        chk3("lu_go", 1'b0, 32'h0, 32'd1);
        idle();
        chk3("alu_noentry", 1'b0, 32'h0, 32'd1);

        // Latency-3 producer of x7: dependent stalls three cycles.
        drive(1, 0, 0, 0, 0, 7, 1, 3, 0);
        chk3("l3_issue", 1'b0, 32'h0, 32'd1);
        for (int k = 0; k < 3; k++) begin
            drive(1, 7, 1, 0, 0, 0, 0, 0, 0);
            chk3("l3_stall", 1'b1, bit_of(7), 32'd1 + k);
        end
        drive(1, 7, 1, 0, 0, 0, 0, 0, 0);
        chk3("l3_go", 1'b0, 32'h0, 32'd4);

        // Reads of x0 or unused sources never stall.
        drive(1, 0, 0, 0, 0, 7, 1, 3, 0);
        drive(1, 0, 1, 7, 0, 0, 0, 0, 0);
        chk3("x0_read", 1'b0, bit_of(7), 32'd4);
        drive(1, 7, 0, 7, 0, 0, 0, 0, 0);
        chk3("nouse_read", 1'b0, bit_of(7), 32'd4);
        idle();
        idle();
        chk3("drain", 1'b0, 32'h0, 32'd4);

        // lw x5 squashed by a flush the next cycle.
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
        drive(1, 5, 1, 0, 0, 6, 1, 0, 1);
        chk3("flush_beats_stall", 1'b0, bit_of(5), 32'd4);
        drive(1, 5, 1, 0, 0, 6, 1, 0, 0);
        chk3("flush_cleared", 1'b0, 32'h0, 32'd4);

        // WAW: lat-3 then lat-1 to x8; newest latency governs.
        drive(1, 0, 0, 0, 0, 8, 1, 3, 0);
        drive(1, 0, 0, 0, 0, 8, 1, 1, 0);
        chk3("waw_second", 1'b0, bit_of(8), 32'd4);
        drive(1, 8, 1, 0, 0, 0, 0, 0, 0);
        chk3("waw_stall", 1'b1, bit_of(8), 32'd4);
        drive(1, 8, 1, 0, 0, 0, 0, 0, 0);
        chk3("waw_go", 1'b0, 32'h0, 32'd5);

        // Two lat-7 stalls push the 4-bit counter past all-ones.
        exp_sc = 32'd5;
        for (int rep = 0; rep < 2; rep++) begin
            drive(1, 0, 0, 0, 0, 9, 1, 7, 0);
            for (int k = 0; k < 7; k++) begin
                drive(1, 0, 0, 9, 1, 0, 0, 0, 0);
                chk3("sat_stall", 1'b1, bit_of(9), exp_sc);
                if (exp_sc < 32'd15) exp_sc = exp_sc + 32'd1;
            end
            drive(1, 0, 0, 9, 1, 0, 0, 0, 0);
            chk3("sat_go", 1'b0, 32'h0, exp_sc);
        end
        check("sat_final", {28'b0, stall_count}, 32'd15);

        // Asynchronous reset in the middle of a stall.
        drive(1, 0, 0, 0, 0, 9, 1, 7, 0);
        drive(1, 9, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 9, 1, 0, 0, 0, 0, 0, 0);
        chk3("pre_rst", 1'b1, bit_of(9), 32'd15);
        #2 rst = 1'b1;
        #1;
        chk3("async_rst", 1'b0, 32'h0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 9, 1, 0, 0, 0, 0, 0, 0);
        chk3("post_rst", 1'b0, 32'h0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
